// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and constants for the SPI transfer scheduler.
//            Defines the scheduler state encoding, the command word layout
//            ({slave, data}), the idle chip-select pattern and the reserved
//            slave id that is reported as an error instead of launched.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_SLAVE_W = 2;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_CMD_W   = SPI_SLAVE_W + SPI_DATA_W;

  // Master chip selects are active-low; all ones means no slave selected.
  localparam logic [2:0] CS_IDLE = 3'b111;

  // Only three chip selects exist, so id 3 has no slave behind it.
  localparam logic [SPI_SLAVE_W-1:0] SLAVE_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_SEL  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RESPOND   = 3'd5
  } spi_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_fifo
// Purpose  : Synchronous first-word-fall-through FIFO holding queued SPI
//            commands. The head entry is always visible on pop_data.
// Ports    : clk, reset_n     - clock, asynchronous active-low reset
//            push, push_data  - write request (ignored when full)
//            pop, pop_data    - read request (ignored when empty), head entry
//            full, empty      - occupancy flags
//            level            - number of stored entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = SPI_CMD_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == LVL_FULL);
  assign empty    = (count == '0);
  assign level    = count;

endmodule
`default_nettype wire

// File: rtl/spi_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_transfer_scheduler
// Purpose  : Queues SPI byte-transfer commands and launches them one at a
//            time on an SPI master, watching the master's chip selects to
//            detect completion and returning the received byte (or an error
//            for timeouts and invalid slave ids) on a response port.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            cmd_valid/ready/slave/data   - command request channel
//            rsp_valid/ready/data/slave/err - response channel
//            start, slaveSelect,
//            masterDataToSend             - drive the SPI master
//            masterDataReceived, CS       - observed from the SPI master
//            busy, level                  - activity and queue occupancy
// Revision : 1.0 - initial release
// ============================================================================
module spi_transfer_scheduler
  import spi_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SPI_SLAVE_W-1:0] cmd_slave,
  input  logic [SPI_DATA_W-1:0]  cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SPI_DATA_W-1:0]  rsp_data,
  output logic [SPI_SLAVE_W-1:0] rsp_slave,
  output logic                   rsp_err,
  output logic                   start,
  output logic [SPI_SLAVE_W-1:0] slaveSelect,
  output logic [SPI_DATA_W-1:0]  masterDataToSend,
  input  logic [SPI_DATA_W-1:0]  masterDataReceived,
  input  logic [2:0]             CS,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] TIMER_MAX = '1;
  localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT);

  spi_sched_state_t state, state_next;

  logic [SPI_CMD_W-1:0]   head;
  logic [SPI_SLAVE_W-1:0] head_slave;
  logic [SPI_DATA_W-1:0]  head_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  logic [TW-1:0]          timer, timer_next, timer_inc;
  logic                   timeout_hit;

  logic                   start_next;
  logic [SPI_SLAVE_W-1:0] sel_next;
  logic [SPI_DATA_W-1:0]  tx_next;
  logic                   rsp_valid_next;
  logic [SPI_DATA_W-1:0]  rsp_data_next;
  logic [SPI_SLAVE_W-1:0] rsp_slave_next;
  logic                   rsp_err_next;

  spi_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SPI_CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data ({cmd_slave, cmd_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign head_slave = head[SPI_CMD_W-1 -: SPI_SLAVE_W];
  assign head_data  = head[SPI_DATA_W-1:0];

  assign cmd_ready  = !fifo_full;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  // Saturating so a long stall never wraps back below the limit.
  assign timer_inc   = (timer == TIMER_MAX) ? timer : timer + TIMER_ONE;
  // Abort once the cycles spent in the wait state reach TIMEOUT.
  assign timeout_hit = (timer_inc == TIMER_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      timer            <= '0;
      start            <= 1'b0;
      slaveSelect      <= SLAVE_INVALID;
      masterDataToSend <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_slave        <= '0;
      rsp_err          <= 1'b0;
    end else begin
      state            <= state_next;
      timer            <= timer_next;
      start            <= start_next;
      slaveSelect      <= sel_next;
      masterDataToSend <= tx_next;
      rsp_valid        <= rsp_valid_next;
      rsp_data         <= rsp_data_next;
      rsp_slave        <= rsp_slave_next;
      rsp_err          <= rsp_err_next;
    end
  end

  // Outputs are registered: each branch computes the value the output
  // takes in the state being entered (start is high exactly in LAUNCH).
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    timer_next     = timer_inc;
    start_next     = 1'b0;
    sel_next       = slaveSelect;
    tx_next        = masterDataToSend;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    rsp_slave_next = rsp_slave;
    rsp_err_next   = rsp_err;

    case (state)
      ST_IDLE: begin
        // CS must be idle so a master transfer still running after a
        // reset of this block is never overlapped.
        if (!fifo_empty && (CS == CS_IDLE) && !rsp_valid) begin
          pop            = 1'b1;
          sel_next       = head_slave;
          tx_next        = head_data;
          rsp_slave_next = head_slave;
          if (head_slave == SLAVE_INVALID) begin
            state_next     = ST_RESPOND;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_data_next  = '0;
          end else begin
            state_next = ST_LAUNCH;
            start_next = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT_SEL;
        timer_next = '0;
      end
      ST_WAIT_SEL: begin
        if (CS != CS_IDLE) begin
          state_next = ST_WAIT_DONE;
          timer_next = '0;
        end else if (timeout_hit) begin
          state_next     = ST_RESPOND;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_data_next  = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (CS == CS_IDLE) begin
          state_next = ST_SETTLE;
        end else if (timeout_hit) begin
          state_next     = ST_RESPOND;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_data_next  = '0;
        end
      end
      ST_SETTLE: begin
        // The master updates its receive register on the falling edge,
        // so the byte is only trustworthy one cycle after CS goes idle.
        state_next     = ST_RESPOND;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_data_next  = masterDataReceived;
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_transfer_scheduler
// Purpose  : Self-checking bench for spi_transfer_scheduler. A behavioural
//            SPI master/slave model answers each launched byte with
//            (sent byte XOR per-slave key); expected responses are derived
//            from a queue of accepted commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_transfer_scheduler;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  typedef struct {
    logic [1:0] slave;
    logic [7:0] data;
  } cmd_t;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_slave;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_slave;
  logic       rsp_err;
  logic       start;
  logic [1:0] slaveSelect;
  logic [7:0] masterDataToSend;
  logic [7:0] masterDataReceived;
  logic [2:0] CS;
  logic       busy;
  logic [2:0] level;

  int   total = 0;
  int   bad = 0;
  cmd_t exp_q[$];
  logic [7:0] key [4];
  bit   master_alive;
  int   start_cnt = 0;
  int   overlap_cnt = 0;
  int   min_gap = 1000;
  int   gap_run = 1000;

  spi_transfer_scheduler #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_slave          (cmd_slave),
    .cmd_data           (cmd_data),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_slave          (rsp_slave),
    .rsp_err            (rsp_err),
    .start              (start),
    .slaveSelect        (slaveSelect),
    .masterDataToSend   (masterDataToSend),
    .masterDataReceived (masterDataReceived),
    .CS                 (CS),
    .busy               (busy),
    .level              (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI master + slaves: one idle cycle, CS low for 8 cycles, then the
  // reply byte appears together with CS returning idle.
  initial begin
    logic [1:0] sel_l;
    logic [7:0] reply;
    CS = 3'b111;
    masterDataReceived = 8'h00;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && master_alive) begin
        sel_l = slaveSelect;
        reply = masterDataToSend ^ key[sel_l];
        @(negedge clk);
        CS = ~(3'b001 << sel_l);
        repeat (8) @(negedge clk);
        masterDataReceived = reply;
        CS = 3'b111;
      end
    end
  end

  // Start-pulse monitor: counts pulses, shortest low gap, launches over a busy master.
  initial begin
    forever begin
      @(negedge clk);
      if (start === 1'b1) begin
        start_cnt++;
        if (gap_run < min_gap) min_gap = gap_run;
        gap_run = 0;
        if (CS !== 3'b111) overlap_cnt++;
      end else begin
        gap_run++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data), 32'h00);
    check({tag, "_rsp_slave"}, 32'(rsp_slave), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    check({tag, "_start"},     32'(start), 32'd0);
    check({tag, "_sel"},       32'(slaveSelect), 32'd3);
    check({tag, "_mdts"},      32'(masterDataToSend), 32'h00);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_level"},     32'(level), 32'd0);
  endtask

  task automatic push(input logic [1:0] s, input logic [7:0] d);
    int   n;
    cmd_t c;
    n = 0;
    cmd_valid = 1'b1;
    cmd_slave = s;
    cmd_data  = d;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    c.slave = s;
    c.data  = d;
    exp_q.push_back(c);
  endtask

  task automatic get_rsp(input string tag, input bit timed_out);
    int         n;
    int         hold;
    cmd_t       c;
    bit         ee;
    logic [7:0] ed;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(rsp_valid), 32'd1);
    check({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      c  = exp_q.pop_front();
      ee = (c.slave == 2'd3) || timed_out;
      ed = ee ? 8'h00 : (c.data ^ key[c.slave]);
      hold = $urandom_range(0, 2);
      repeat (hold) @(negedge clk);
      check({tag, "_data"},  32'(rsp_data), 32'(ed));
      check({tag, "_slave"}, 32'(rsp_slave), 32'(c.slave));
      check({tag, "_err"},   32'(rsp_err), 32'(ee));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int         n;
    int         s0;
    int         unstable;
    logic [7:0] held;

    reset_n      = 1'b0;
    cmd_valid    = 1'b0;
    cmd_slave    = 2'd0;
    cmd_data     = 8'h00;
    rsp_ready    = 1'b0;
    master_alive = 1'b1;
    key[0] = 8'h11; key[1] = 8'h99; key[2] = 8'h5A; key[3] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single transfer to slave 1; key makes the reply 8'h3C.
    s0 = start_cnt;
    push(2'd1, 8'hA5);
    check("t1_level", 32'(level), 32'd1);
    check("t1_nostart_yet", 32'(start), 32'd0);
    @(negedge clk);
    check("t1_start", 32'(start), 32'd1);
    check("t1_sel", 32'(slaveSelect), 32'd1);
    check("t1_mdts", 32'(masterDataToSend), 32'hA5);
    @(negedge clk);
    check("t1_one_cycle", 32'(start), 32'd0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_rsp_3c", 32'(rsp_data), 32'h3C);
    get_rsp("t1", 1'b0);
    check("t1_start_count", 32'(start_cnt - s0), 32'd1);

    // Invalid slave: error response within 3 cycles and no start.
    s0 = start_cnt;
    push(2'd3, 8'hFF);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 3) begin
      @(negedge clk);
      n++;
    end
    check("t3_latency", 32'(rsp_valid), 32'd1);
    get_rsp("t3", 1'b0);
    check("t3_no_start", 32'(start_cnt - s0), 32'd0);

    // Five back-to-back pushes: one pops, so the queue ends full.
    for (int i = 0; i < 5; i++) begin
      push(2'($urandom_range(0, 2)), 8'($urandom));
    end
    check("t2_level_full", 32'(level), 32'd4);
    check("t2_ready_low", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      get_rsp("t2", 1'b0);
    end

    // Unresponsive master: timeout then the next command launches.
    master_alive = 1'b0;
    push(2'd0, 8'h42);
    push(2'd2, 8'h24);
    n = 0;
    while (start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_start", 32'(start), 32'd1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
    master_alive = 1'b1;
    s0 = start_cnt;
    get_rsp("t4a", 1'b1);
    get_rsp("t4b", 1'b0);
    check("t4_next_launched", 32'(start_cnt - s0), 32'd1);

    // Response back-pressure: data stays put and nothing else launches.
    push(2'd0, 8'h81);
    push(2'd1, 8'h7E);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    held = rsp_data;
    s0 = start_cnt;
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== held) unstable++;
    end
    check("t5_stable", 32'(unstable), 32'd0);
    check("t5_no_start", 32'(start_cnt - s0), 32'd0);
    check("t5_level", 32'(level), 32'd1);
    get_rsp("t5a", 1'b0);
    get_rsp("t5b", 1'b0);

    // Randomised batches with random keys and slave ids (incl. invalid).
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) key[k] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
        push(2'($urandom_range(0, 3)), 8'($urandom));
      end
      for (int i = 0; i < 3; i++) begin
        get_rsp("rand", 1'b0);
      end
    end

    // Reset while the master is mid-transfer.
    push(2'd0, 8'h33);
    n = 0;
    while (CS === 3'b111 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_master_busy", 32'(CS != 3'b111), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("t6_reset");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    push(2'd2, 8'hC3);
    n = 0;
    while (start !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("t6_start", 32'(start), 32'd1);
    check("t6_cs_idle_at_start", 32'(CS), 32'h7);
    get_rsp("t6", 1'b0);

    check("start_gap_ge4", 32'(min_gap >= 4), 32'd1);
    check("no_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
